// File: rtl/phy_rx.sv
// rtl/phy_rx.sv - two-lane serial receive PHY: comma alignment, word packing, un-striping
//
// Ports:
//   clk_32f        bit-rate clock, all state changes on its rising edge
//   reset          synchronous active-high reset
//   data_in_lane0  lane0 serial bit, MSB-first
//   data_in_lane1  lane1 serial bit, MSB-first
//   data_out       recovered 32-bit word (byte 3 = first byte received)
//   valid_out      one-cycle strobe qualifying data_out
//   active_out     high while both lanes are aligned
//   err_overflow   sticky flag: a lane word overwrote an unsent held word
module phy_rx #(
    parameter logic [7:0] COM         = 8'hBC,
    parameter int         ALIGN_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in_lane0,
    input  logic        data_in_lane1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active_out,
    output logic        err_overflow
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ALIGNED = 2'd2
    } lane_state_t;

    // com_cnt value at which the next on-boundary COM completes alignment
    localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_COUNT - 1);

    logic [1:0]  lane_bit;
    lane_state_t state    [2];
    logic [7:0]  shift    [2];
    logic [2:0]  bit_cnt  [2];
    logic [7:0]  com_cnt  [2];
    logic [1:0]  byte_idx [2];
    logic [23:0] partial  [2];

    logic [1:0]  word_done;
    logic [1:0]  aligned;
    logic [31:0] lane_word [2];

    logic [31:0] hold [2];
    logic [1:0]  full;
    logic        next_lane;
    logic        emit;

    assign lane_bit = {data_in_lane1, data_in_lane0};

    // bit_cnt == 7 marks the edge at which shift holds a complete byte.
    // The fourth byte is taken straight from the shift register so the
    // holding register can load on the very next edge after the last bit.
    always_comb begin
        word_done = '0;
        aligned   = '0;
        for (int i = 0; i < 2; i++) begin
            aligned[i]   = (state[i] == ALIGNED);
            word_done[i] = (state[i] == ALIGNED) && (bit_cnt[i] == 3'd7) &&
                           (byte_idx[i] == 2'd3);
            lane_word[i] = {partial[i], shift[i]};
        end
    end

    // Per-lane shift register, alignment FSM and byte packing
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state[i]    <= SEARCH;
                shift[i]    <= '0;
                bit_cnt[i]  <= '0;
                com_cnt[i]  <= '0;
                byte_idx[i] <= '0;
                partial[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                shift[i] <= {shift[i][6:0], lane_bit[i]};
                case (state[i])
                    SEARCH: begin
                        // Bit-by-bit hunt; the bit shifted in on the matching
                        // edge is bit 0 of the next byte, hence counter = 0.
                        if (shift[i] == COM) begin
                            bit_cnt[i] <= '0;
                            com_cnt[i] <= 8'd1;
                            state[i]   <= LOCKING;
                        end
                    end
                    LOCKING: begin
                        bit_cnt[i] <= bit_cnt[i] + 3'd1;
                        if (bit_cnt[i] == 3'd7) begin
                            if (shift[i] == COM) begin
                                com_cnt[i] <= com_cnt[i] + 8'd1;
                                if (com_cnt[i] == ALIGN_LAST)
                                    state[i] <= ALIGNED;
                            end else begin
                                com_cnt[i] <= '0;
                                state[i]   <= SEARCH;
                            end
                        end
                    end
                    ALIGNED: begin
                        bit_cnt[i] <= bit_cnt[i] + 3'd1;
                        // COM in the first byte slot is idle fill; inside a
                        // word every byte value is payload.
                        if (bit_cnt[i] == 3'd7 &&
                            !(byte_idx[i] == 2'd0 && shift[i] == COM)) begin
                            partial[i]  <= {partial[i][15:0], shift[i]};
                            byte_idx[i] <= byte_idx[i] + 2'd1;
                        end
                    end
                    default: state[i] <= SEARCH;
                endcase
            end
        end
    end

    assign emit = full[next_lane];

    // Un-striping: strict lane0/lane1 alternation, one word per cycle
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            data_out     <= '0;
            valid_out    <= 1'b0;
            active_out   <= 1'b0;
            err_overflow <= 1'b0;
            full         <= '0;
            next_lane    <= 1'b0;
            hold[0]      <= '0;
            hold[1]      <= '0;
        end else begin
            active_out <= aligned[0] & aligned[1];
            valid_out  <= 1'b0;
            if (emit) begin
                data_out        <= hold[next_lane];
                valid_out       <= 1'b1;
                full[next_lane] <= 1'b0;
                next_lane       <= ~next_lane;
            end
            // Loads come after the emit clear so a same-cycle refill wins.
            // A word leaving on this edge is not lost, so no overflow then.
            for (int i = 0; i < 2; i++) begin
                if (word_done[i] && active_out) begin
                    hold[i] <= lane_word[i];
                    full[i] <= 1'b1;
                    if (full[i] && !(emit && next_lane == 1'(i)))
                        err_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_phy_rx.sv
// tb/tb_phy_rx.sv - directed self-checking bench for phy_rx
module tb_phy_rx;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic        data_in_lane0;
    logic        data_in_lane1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active_out;
    logic        err_overflow;

    phy_rx dut (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .data_in_lane0(data_in_lane0),
        .data_in_lane1(data_in_lane1),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .active_out   (active_out),
        .err_overflow (err_overflow)
    );

    always #5 clk_32f = ~clk_32f;

    int          checks = 0;
    int          failures = 0;
    int          cyc;
    int          first_active;
    int          first_err;
    logic        q0[$];
    logic        q1[$];
    int          got_cyc[$];
    logic [31:0] got_dat[$];
    int          exp_cyc[$];
    logic [31:0] exp_dat[$];
    int          k;
    int          k_align;
    int          k_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic put(input int lane, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (lane == 0) q0.push_back(b[i]);
            else           q1.push_back(b[i]);
        end
    endtask

    task automatic put_word(input int lane, input logic [31:0] w);
        put(lane, w[31:24]);
        put(lane, w[23:16]);
        put(lane, w[15:8]);
        put(lane, w[7:0]);
    endtask

    task automatic put_both(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            put(0, b);
            put(1, b);
        end
    endtask

    task automatic expect_word(input int c, input logic [31:0] d);
        exp_cyc.push_back(c);
        exp_dat.push_back(d);
    endtask

    // One bit per lane per edge; outputs sampled 1 time unit after the edge.
    task automatic step();
        data_in_lane0 = (q0.size() > 0) ? q0.pop_front() : 1'b0;
        data_in_lane1 = (q1.size() > 0) ? q1.pop_front() : 1'b0;
        @(posedge clk_32f);
        #1;
        cyc++;
        if (valid_out) begin
            got_cyc.push_back(cyc);
            got_dat.push_back(data_out);
        end
        if (active_out && first_active < 0) first_active = cyc;
        if (err_overflow && first_err < 0) first_err = cyc;
    endtask

    task automatic run(input int extra);
        int n;
        n = (q0.size() > q1.size()) ? q0.size() : q1.size();
        repeat (n + extra) step();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            data_in_lane0 = 1'($urandom_range(0, 1));
            data_in_lane1 = 1'($urandom_range(0, 1));
            @(posedge clk_32f);
            #1;
        end
        reset = 1'b0;
        cyc = 0;
        first_active = -1;
        first_err = -1;
        q0.delete();
        q1.delete();
        got_cyc.delete();
        got_dat.delete();
        exp_cyc.delete();
        exp_dat.delete();
    endtask

    task automatic compare_log(input string ph);
        int n;
        check({ph, "_nwords"}, got_cyc.size(), exp_cyc.size());
        n = (got_cyc.size() < exp_cyc.size()) ? got_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d_cycle", ph, i), got_cyc[i], exp_cyc[i]);
            check($sformatf("%s_w%0d_data", ph, i), got_dat[i], exp_dat[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        data_in_lane0 = 1'b0;
        data_in_lane1 = 1'b0;

        // Reset values with random serial input
        do_reset(3);
        check("rst_data_out", data_out, 32'h0);
        check("rst_valid_out", {31'h0, valid_out}, 32'h0);
        check("rst_active_out", {31'h0, active_out}, 32'h0);
        check("rst_err_overflow", {31'h0, err_overflow}, 32'h0);

        // No COM, then only three COMs followed by a non-COM byte
        put_both(8'h00, 3);
        put_both(8'hBC, 3);
        put_both(8'h00, 3);
        run(2);
        check("nolock_active", first_active, -1);
        check("nolock_nwords", got_cyc.size(), 0);

        // Main stream: alignment, basic data, skew, intact COM bytes, overflow
        do_reset(2);
        put(0, 8'h05); q0.delete(); // discard; garbage is pushed bitwise below
        q0.push_back(1'b1); q0.push_back(1'b0); q0.push_back(1'b1);
        q1.push_back(1'b1); q1.push_back(1'b0); q1.push_back(1'b1);
        put_both(8'hBC, 4);
        k_align = q0.size();
        put_both(8'hBC, 2);

        put_word(0, 32'h11223344);
        put_word(1, 32'h55667788);
        k = q0.size();
        expect_word(k + 2, 32'h11223344);
        expect_word(k + 3, 32'h55667788);
        put_both(8'hBC, 2);

        put_word(1, 32'hCAFEBABE);
        put(1, 8'hBC); put(1, 8'hBC);
        put(0, 8'hBC); put(0, 8'hBC);
        put_word(0, 32'hDEADBEEF);
        k = q0.size();
        expect_word(k + 2, 32'hDEADBEEF);
        expect_word(k + 3, 32'hCAFEBABE);
        put_both(8'hBC, 1);

        put_word(0, 32'h12BC34BC);
        put_word(1, 32'h00BCBCBC);
        k = q0.size();
        expect_word(k + 2, 32'h12BC34BC);
        expect_word(k + 3, 32'h00BCBCBC);
        put_both(8'hBC, 1);

        put_word(1, 32'hA0000001);
        put(1, 8'hBC);
        put_word(1, 32'hA0000002);
        k_err = q1.size();
        for (int i = 0; i < 9; i++) put(0, 8'hBC);
        put_word(0, 32'h00000000);
        for (int i = 0; i < 4; i++) put(1, 8'hBC);
        k = q0.size();
        expect_word(k + 2, 32'h00000000);
        expect_word(k + 3, 32'hA0000002);
        put_both(8'hBC, 3);

        run(4);
        check("align_active_cycle", first_active, k_align + 2);
        check("overflow_cycle", first_err, k_err + 1);
        compare_log("main");

        // Mid-word reset: two bytes of a word, then reset
        q0.delete(); q1.delete();
        put(0, 8'h99); put(0, 8'h88);
        put(1, 8'h77); put(1, 8'h66);
        run(0);
        do_reset(2);
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_valid_out", {31'h0, valid_out}, 32'h0);
        check("midrst_active_out", {31'h0, active_out}, 32'h0);
        check("midrst_err_overflow", {31'h0, err_overflow}, 32'h0);

        for (int i = 1; i <= 8; i++) begin
            put(0, 8'(i));
            put(1, 8'(8'h10 + i));
        end
        put_both(8'hBC, 4);
        k_align = q0.size();
        put_both(8'hBC, 1);
        put_word(0, 32'hA1B2C3D4);
        put_word(1, 32'h5A5A5A5A);
        k = q0.size();
        expect_word(k + 2, 32'hA1B2C3D4);
        expect_word(k + 3, 32'h5A5A5A5A);
        put_both(8'hBC, 2);
        run(4);
        check("realign_active_cycle", first_active, k_align + 2);
        compare_log("realign");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
